fft_spectrum_capture: RTL and testbench
=======================================

FFT_SPECTRUM_CAPTURE -- requirements
Module: fft_spectrum_capture

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 16: width of one FFT component (real or imaginary).
REQ-002 Parameter FFT_LENGTH_LOG2, default 8: log2 of frame length N (N = 256).
REQ-003 aclk  in  1  single clock, all logic on rising edge.
REQ-004 areset  in  1  reset, synchronous and active-high.
REQ-005 S_AXIS_fft_tdata  in  2*AXIS_TDATA_WIDTH  FFT bin, [W-1:0] = signed real, [2W-1:W] = signed imaginary.
REQ-006 S_AXIS_fft_tvalid  in  1  bin valid.
REQ-007 S_AXIS_fft_tlast  in  1  last bin of frame.
REQ-008 S_AXIS_fft_tready  out  1  sink ready.
REQ-009 arm  in  1  one-cycle pulse requesting capture of the next whole frame.
REQ-010 rd_en  in  1  buffer read strobe.
REQ-011 rd_addr  in  FFT_LENGTH_LOG2  bin index to read.
REQ-012 rd_data  out  2*AXIS_TDATA_WIDTH+1  bin power (unsigned), valid 1 cycle after rd_en.
REQ-013 busy  out  1  high in WAIT_SOF or CAPTURE.
REQ-014 done  out  1  high in DONE.
REQ-015 len_err  out  1  sticky: last captured frame length differed from N.

Function
REQ-016 Beat = cycle with tvalid high; S_AXIS_fft_tready SHALL be 1 in every state after reset, so the upstream FFT never stalls; beats outside CAPTURE are discarded.
REQ-017 FSM states: IDLE, WAIT_SOF, CAPTURE, DONE.
REQ-018 IDLE -> WAIT_SOF on arm; arm is ignored in WAIT_SOF/CAPTURE; arm in DONE clears done and len_err and enters WAIT_SOF.
REQ-019 WAIT_SOF: a frame starts on the beat after a tlast beat; the module SHALL track this with an sof flag set by reset and by every tlast beat, cleared by every non-tlast beat.
REQ-020 WAIT_SOF -> CAPTURE on a beat with sof=1; that beat is bin 0 and is captured.
REQ-021 CAPTURE: each beat is written to address bin_cnt, bin_cnt increments, wrapping modulo N.
REQ-022 Frame end: tlast beat, or the N-th beat, whichever comes first; CAPTURE -> DONE after the final write retires (pipeline drained).
REQ-023 len_err SHALL be set if tlast arrives on a beat other than bin N-1, or bin N-1 carries tlast=0.
REQ-024 Power = re*re + im*im, signed products, unsigned (2W+1)-bit sum, no truncation; -32768^2*2 = 2^31 is exact.
REQ-025 Power pipeline: stage 1 registers both products, stage 2 registers sum and writes buffer; write latency 2 cycles from beat.
REQ-026 Buffer: N x (2W+1) simple dual-port RAM, synchronous read, rd_data registered, 1-cycle latency; rd_data holds value when rd_en low.
REQ-027 Read during CAPTURE is allowed; returns old or new contents at the colliding address, undefined which.
REQ-028 DONE persists until arm or reset.

Reset
REQ-029 areset SHALL force state IDLE, bin_cnt 0, sof 1, busy 0, done 0, len_err 0, rd_data 0, pipeline valid bits 0, tready 1; RAM contents not cleared.
REQ-030 areset mid-capture abandons the frame; the in-flight pipeline writes are suppressed.

Configuration
REQ-031 Macro FFT_CAPTURE_RAW_EN: when defined, the buffer stores raw tdata zero-extended to 2W+1 bits instead of power, keeping the same 2-cycle write latency; when undefined, power per REQ-024.

Structure
REQ-032 Shared package fft_capture_pkg holds the state enum type and the power-width constant function (2W+1).
REQ-033 Buffer is one sub-module, capture_ram (parameterized depth/width, 1 write port, 1 registered read port).

Verification
REQ-034 Reset, arm, stream 3 frames N=256 with re=bin, im=0, tlast on 255 -> capture starts frame 2 bin 0, rd_addr 5 returns 25, done=1, len_err=0.
REQ-035 re=-32768, im=-32768 on all bins -> rd_data = 2147483648 (0x080000000) at every address.
REQ-036 arm mid-frame (bin 100 of current frame) -> bins 101..255 ignored, capture begins next bin 0.
REQ-037 Short frame, tlast on bin 199 -> DONE after bin 199 write, len_err=1; next arm clears len_err.
REQ-038 areset asserted at bin 50 of capture -> IDLE, busy=0, done=0; re-arm captures a complete frame correctly.
REQ-039 With FFT_CAPTURE_RAW_EN, tdata=0x00030004 on bin 7 -> rd_addr 7 returns 0x000030004.

Source files
------------

// File: rtl/fft_capture_pkg.sv
// Shared definitions for the FFT spectrum capture block: FSM state type and
// the width of one stored buffer word.
package fft_capture_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } capture_state_t;

    // Width of one stored word: re^2 + im^2 of two signed w-bit values needs
    // 2w+1 bits to stay exact, e.g. (-2^(w-1))^2 * 2 = 2^(2w-1).
    function automatic int power_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port buffer: one synchronous write port, one registered read
// port. Read data updates only on rd_en and is cleared by rst; the array
// itself is never cleared. A read and write to the same address in the same
// cycle returns either the old or the new word.
module capture_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, holds its value while rd_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_spectrum_capture.sv
// FFT spectrum capture: on an arm pulse, waits for the next frame start in an
// always-ready AXI-Stream of FFT bins, stores one whole frame as bin power
// (re^2 + im^2) into a buffer readable through rd_en/rd_addr, then parks in
// DONE. Optional macro FFT_CAPTURE_RAW_EN stores raw tdata (zero-extended)
// instead of power, with the same two-cycle write latency.
//
// Handshake: S_AXIS_fft_tready is tied high, so every cycle with tvalid high
// is a beat and is consumed; beats not needed for the capture are dropped.
module fft_spectrum_capture
    import fft_capture_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int FFT_LENGTH_LOG2  = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [2*AXIS_TDATA_WIDTH-1:0] S_AXIS_fft_tdata,
    input  logic                          S_AXIS_fft_tvalid,
    input  logic                          S_AXIS_fft_tlast,
    output logic                          S_AXIS_fft_tready,
    input  logic                          arm,
    input  logic                          rd_en,
    input  logic [FFT_LENGTH_LOG2-1:0]    rd_addr,
    output logic [2*AXIS_TDATA_WIDTH:0]   rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          len_err,
    output logic [1:0]                    dbg_state
);

    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int PW = power_width(AXIS_TDATA_WIDTH);
    localparam int L  = FFT_LENGTH_LOG2;
    localparam logic [L-1:0] LAST_BIN = '1;

    capture_state_t state, state_next;

    logic         sof;        // next beat is bin 0 of a frame
    logic [L-1:0] bin_cnt;    // address of the next captured bin
    logic         ending;     // final beat taken, waiting for the pipeline
    logic         len_err_q;
    logic         rearm;      // arm accepted this cycle

    logic         beat;
    logic         cap_beat;
    logic [L-1:0] cap_idx;
    logic         last_bin;
    logic         frame_end;
    logic         len_bad;

    logic         s1_valid;
    logic [L-1:0] s1_addr;
    logic         wr_en;
    logic [PW-1:0] wr_data;

`ifdef FFT_CAPTURE_RAW_EN
    logic [2*W-1:0] s1_raw;
`else
    logic signed [W-1:0]   bin_re;
    logic signed [W-1:0]   bin_im;
    logic signed [2*W-1:0] s1_re_sq;
    logic signed [2*W-1:0] s1_im_sq;
`endif

    assign S_AXIS_fft_tready = 1'b1;
    assign beat              = S_AXIS_fft_tvalid;
    assign len_err           = len_err_q;
    assign dbg_state         = state;

    // Beat qualification: the first capture beat is always bin 0, later
    // beats land at bin_cnt; nothing is taken once the final beat is in.
    assign cap_idx   = (state == CAPTURE) ? bin_cnt : '0;
    assign cap_beat  = beat && (((state == WAIT_SOF) && sof) ||
                                ((state == CAPTURE) && !ending));
    assign last_bin  = (cap_idx == LAST_BIN);
    assign frame_end = cap_beat && (S_AXIS_fft_tlast || last_bin);
    assign len_bad   = cap_beat && (S_AXIS_fft_tlast != last_bin);

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        rearm      = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = WAIT_SOF;
                    rearm      = 1'b1;
                end
            end
            WAIT_SOF: begin
                busy = 1'b1;
                if (cap_beat) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                // Last write retires in the cycle s1_valid is high
                if (ending && !s1_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (arm) begin
                    state_next = WAIT_SOF;
                    rearm      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame tracking: start-of-frame flag, bin counter, end and length flags
    always_ff @(posedge aclk) begin
        if (areset) begin
            sof       <= 1'b1;
            bin_cnt   <= '0;
            ending    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            if (beat) begin
                sof <= S_AXIS_fft_tlast;
            end
            if (rearm) begin
                bin_cnt   <= '0;
                ending    <= 1'b0;
                len_err_q <= 1'b0;
            end else begin
                if (cap_beat) begin
                    bin_cnt <= cap_idx + 1'b1;
                end
                if (frame_end) begin
                    ending <= 1'b1;
                end
                if (len_bad) begin
                    len_err_q <= 1'b1;
                end
            end
        end
    end

    // Stage 1 valid and address
    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= cap_beat;
        end
    end

    // Stage 1 address, no reset needed (qualified by s1_valid)
    always_ff @(posedge aclk) begin
        s1_addr <= cap_idx;
    end

`ifdef FFT_CAPTURE_RAW_EN
    // Stage 1 data: raw bin word
    always_ff @(posedge aclk) begin
        s1_raw <= S_AXIS_fft_tdata;
    end

    assign wr_data = {1'b0, s1_raw};
`else
    assign bin_re = S_AXIS_fft_tdata[W-1:0];
    assign bin_im = S_AXIS_fft_tdata[2*W-1:W];

    // Stage 1 data: signed squares, each non-negative and at most 2^(2W-2)
    always_ff @(posedge aclk) begin
        s1_re_sq <= bin_re * bin_re;
        s1_im_sq <= bin_im * bin_im;
    end

    // Stage 2 sum, one bit wider so the sum never wraps
    assign wr_data = {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
`endif

    // A reset in the same cycle drops the in-flight write
    assign wr_en = s1_valid && !areset;

    capture_ram #(
        .ADDR_WIDTH (L),
        .DATA_WIDTH (PW)
    ) u_ram (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (wr_en),
        .wr_addr (s1_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Directed testbench for fft_spectrum_capture (default parameters, W=16,
// N=256). Optional macro FFT_CAPTURE_RAW_EN switches the expected-value model
// to raw storage and enables the raw-word test.
module tb_fft_spectrum_capture;

    localparam int W  = 16;
    localparam int L  = 8;
    localparam int PW = 2 * W + 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic [2*W-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          arm;
    logic          rd_en;
    logic [L-1:0]  rd_addr;
    logic [PW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          len_err;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock
    always #5 aclk = ~aclk;

    fft_spectrum_capture #(
        .AXIS_TDATA_WIDTH (W),
        .FFT_LENGTH_LOG2  (L)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .S_AXIS_fft_tdata  (tdata),
        .S_AXIS_fft_tvalid (tvalid),
        .S_AXIS_fft_tlast  (tlast),
        .S_AXIS_fft_tready (tready),
        .arm               (arm),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .busy              (busy),
        .done              (done),
        .len_err           (len_err),
        .dbg_state         (dbg_state)
    );

    // Stimulus patterns, indexed by pattern number and bin
    function automatic logic [W-1:0] pat_re(input int pat, input int bin);
        case (pat)
            1:       return 16'h8000;
            2:       return 16'd7;
            6:       return (bin == 7) ? 16'd4 : 16'(bin);
            default: return 16'(bin);
        endcase
    endfunction

    function automatic logic [W-1:0] pat_im(input int pat, input int bin);
        case (pat)
            1:       return 16'h8000;
            2:       return 16'd3;
            3:       return 16'd1;
            4:       return 16'(bin);
            5:       return 16'd2;
            6:       return (bin == 7) ? 16'd3 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    // Expected stored word for one bin
    function automatic logic [PW-1:0] exp_val(input logic [W-1:0] re, input logic [W-1:0] im);
`ifdef FFT_CAPTURE_RAW_EN
        return {1'b0, im, re};
`else
        longint r;
        longint i;
        r = longint'($signed(re));
        i = longint'($signed(im));
        return PW'(r * r + i * i);
`endif
    endfunction

    function automatic logic [PW-1:0] exp_bin(input int pat, input int bin);
        return exp_val(pat_re(pat, bin), pat_im(pat, bin));
    endfunction

    // Driver: contiguous frame of nbins beats, tlast on the final one;
    // optional arm pulse and reset pulse on chosen bins (-1 = none).
    task automatic send_frame(input int nbins, input int pat, input int arm_at, input int rst_at);
        for (int b = 0; b < nbins; b++) begin
            tdata  = {pat_im(pat, b), pat_re(pat, b)};
            tvalid = 1'b1;
            tlast  = (b == nbins - 1);
            arm    = (b == arm_at);
            areset = (b == rst_at);
            @(negedge aclk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        arm    = 1'b0;
        areset = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge aclk);
        arm = 1'b0;
    endtask

    task automatic read_bin(input int addr, output logic [PW-1:0] data);
        rd_en   = 1'b1;
        rd_addr = L'(addr);
        @(negedge aclk);
        rd_en = 1'b0;
        data  = rd_data;
    endtask

    // Bounded wait for done
    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++;
        if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %0b expected 0", len_err); end
        n_checks++;
        if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %0b expected 1", tready); end
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
    endtask

    // Armed during frame 1 -> frame 2 captured, frame 3 ignored in DONE
    task automatic test_basic_capture();
        logic [PW-1:0] got;
        logic [PW-1:0] held;
        int addrs[$] = '{0, 5, 128, 255};
        send_frame(256, 0, 10, -1);
        n_checks++;
        if (dbg_state !== 2'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_wait_sof: got state %0d busy %0b expected 1 1", dbg_state, busy);
        end
        send_frame(256, 0, -1, -1);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early: got %0b expected 0", done); end
        wait_done();
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b expected 1", done); end
        send_frame(256, 0, -1, -1);
        n_checks++;
        if (dbg_state !== 2'd3 || busy !== 1'b0 || len_err !== 1'b0 || tready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_hold: got state %0d busy %0b len_err %0b tready %0b expected 3 0 0 1",
                     dbg_state, busy, len_err, tready);
        end
        foreach (addrs[i]) begin
            read_bin(addrs[i], got);
            n_checks++;
            if (got !== exp_bin(0, addrs[i])) begin
                n_fail++; $display("FAIL basic_rd[%0d]: got %0d expected %0d", addrs[i], got, exp_bin(0, addrs[i]));
            end
        end
`ifndef FFT_CAPTURE_RAW_EN
        read_bin(5, got);
        n_checks++;
        if (got !== 33'd25) begin n_fail++; $display("FAIL basic_rd5_literal: got %0d expected 25", got); end
`endif
        held    = got;
        rd_addr = 8'd200;
        @(negedge aclk);
        n_checks++;
        if (rd_data !== held) begin n_fail++; $display("FAIL basic_rd_hold: got %0d expected %0d", rd_data, held); end
    endtask

    // Most negative re and im on every bin
    task automatic test_power_max();
        logic [PW-1:0] got;
        int addrs[$] = '{0, 1, 128, 255};
        pulse_arm();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL max_rearm: got done %0b busy %0b expected 0 1", done, busy);
        end
        send_frame(256, 1, -1, -1);
        wait_done();
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL max_done: got %0b expected 1", done); end
        foreach (addrs[i]) begin
            read_bin(addrs[i], got);
            n_checks++;
            if (got !== exp_bin(1, addrs[i])) begin
                n_fail++; $display("FAIL max_rd[%0d]: got %0h expected %0h", addrs[i], got, exp_bin(1, addrs[i]));
            end
        end
`ifndef FFT_CAPTURE_RAW_EN
        n_checks++;
        if (got !== 33'h080000000) begin n_fail++; $display("FAIL max_literal: got %0h expected 080000000", got); end
`endif
    endtask

    // Arm on bin 100: rest of that frame dropped, next frame captured
    task automatic test_arm_mid_frame();
        logic [PW-1:0] got;
        int addrs[$] = '{0, 5, 101, 200};
        send_frame(256, 2, 100, -1);
        n_checks++;
        if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL mid_wait_sof: got %0d expected 1", dbg_state); end
        send_frame(256, 0, -1, -1);
        wait_done();
        n_checks++;
        if (done !== 1'b1 || len_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_done: got done %0b len_err %0b expected 1 0", done, len_err);
        end
        foreach (addrs[i]) begin
            read_bin(addrs[i], got);
            n_checks++;
            if (got !== exp_bin(0, addrs[i])) begin
                n_fail++; $display("FAIL mid_rd[%0d]: got %0d expected %0d", addrs[i], got, exp_bin(0, addrs[i]));
            end
        end
    endtask

    // tlast on bin 199 ends the capture early and flags len_err
    task automatic test_short_frame();
        logic [PW-1:0] got;
        int addrs[$] = '{0, 199, 200};
        int pats[$]  = '{3, 3, 0};
        pulse_arm();
        send_frame(200, 3, -1, -1);
        wait_done();
        n_checks++;
        if (done !== 1'b1 || len_err !== 1'b1) begin
            n_fail++; $display("FAIL short_done: got done %0b len_err %0b expected 1 1", done, len_err);
        end
        foreach (addrs[i]) begin
            read_bin(addrs[i], got);
            n_checks++;
            if (got !== exp_bin(pats[i], addrs[i])) begin
                n_fail++; $display("FAIL short_rd[%0d]: got %0d expected %0d", addrs[i], got, exp_bin(pats[i], addrs[i]));
            end
        end
        pulse_arm();
        n_checks++;
        if (len_err !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL short_rearm_clear: got len_err %0b done %0b expected 0 0", len_err, done);
        end
        send_frame(256, 0, -1, -1);
        wait_done();
        n_checks++;
        if (done !== 1'b1 || len_err !== 1'b0) begin
            n_fail++; $display("FAIL short_next_frame: got done %0b len_err %0b expected 1 0", done, len_err);
        end
    endtask

    // No tlast on bin 255: capture stops after N beats, flags len_err
    task automatic test_long_frame();
        logic [PW-1:0] got;
        int addrs[$] = '{0, 255};
        pulse_arm();
        send_frame(300, 5, -1, -1);
        n_checks++;
        if (done !== 1'b1 || len_err !== 1'b1) begin
            n_fail++; $display("FAIL long_done: got done %0b len_err %0b expected 1 1", done, len_err);
        end
        foreach (addrs[i]) begin
            read_bin(addrs[i], got);
            n_checks++;
            if (got !== exp_bin(5, addrs[i])) begin
                n_fail++; $display("FAIL long_rd[%0d]: got %0d expected %0d", addrs[i], got, exp_bin(5, addrs[i]));
            end
        end
    endtask

    // Reset on capture bin 50: frame abandoned, bin 49 write dropped
    task automatic test_reset_mid_capture();
        logic [PW-1:0] got;
        int addrs[$]  = '{48, 49, 50};
        int pats[$]   = '{4, 5, 5};
        int addrs2[$] = '{0, 49, 50, 255};
        pulse_arm();
        send_frame(256, 4, -1, 50);
        n_checks++;
        if (dbg_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got state %0d busy %0b done %0b len_err %0b expected 0 0 0 0",
                     dbg_state, busy, done, len_err);
        end
        foreach (addrs[i]) begin
            read_bin(addrs[i], got);
            n_checks++;
            if (got !== exp_bin(pats[i], addrs[i])) begin
                n_fail++; $display("FAIL rst_mid_rd[%0d]: got %0d expected %0d", addrs[i], got, exp_bin(pats[i], addrs[i]));
            end
        end
        pulse_arm();
        send_frame(256, 0, -1, -1);
        wait_done();
        n_checks++;
        if (done !== 1'b1 || len_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_rearm_done: got done %0b len_err %0b expected 1 0", done, len_err);
        end
        foreach (addrs2[i]) begin
            read_bin(addrs2[i], got);
            n_checks++;
            if (got !== exp_bin(0, addrs2[i])) begin
                n_fail++; $display("FAIL rst_rearm_rd[%0d]: got %0d expected %0d", addrs2[i], got, exp_bin(0, addrs2[i]));
            end
        end
    endtask

`ifdef FFT_CAPTURE_RAW_EN
    // Raw storage: bin 7 carries tdata 0x00030004
    task automatic test_raw();
        logic [PW-1:0] got;
        pulse_arm();
        send_frame(256, 6, -1, -1);
        wait_done();
        read_bin(7, got);
        n_checks++;
        if (got !== 33'h000030004) begin n_fail++; $display("FAIL raw_rd7: got %0h expected 000030004", got); end
    endtask
`endif

    initial begin
        areset  = 1'b1;
        tdata   = '0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        arm     = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        @(negedge aclk);
        test_reset();
        test_basic_capture();
        test_power_max();
        test_arm_mid_frame();
        test_short_frame();
        test_long_frame();
        test_reset_mid_capture();
`ifdef FFT_CAPTURE_RAW_EN
        test_raw();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
